mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-style main control FSM with retired-instruction counter.
// Optional memory wait-state handshake enabled by defining MC_CTRL_MEM_WAIT_EN.
module mc_ctrl #(
  parameter logic [5:0] OP_R    = 6'd0,
  parameter logic [5:0] OP_LW   = 6'd35,
  parameter logic [5:0] OP_SW   = 6'd43,
  parameter logic [5:0] OP_BEQ  = 6'd4,
  parameter logic [5:0] OP_J    = 6'd2,
  parameter logic [5:0] OP_ADDI = 6'd8,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             pc_write_cond,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem2reg,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_ctrl_op,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXE   = 4'd6,  RWB   = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  IEXE   = 4'd10, IWB   = 4'd11
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   mem_ok;
  logic   hold;
  logic   retire;
  logic   op_known;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign state    = cur_state;
  assign op_known = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  assign hold     = ((cur_state == FETCH) || (cur_state == MEMRD) ||
                     (cur_state == MEMWR)) && !mem_ok;
  assign retire   = ((cur_state == MEMWB) || (cur_state == MEMWR) ||
                     (cur_state == RWB) || (cur_state == BRANCH) ||
                     (cur_state == JUMP) || (cur_state == IWB)) && !hold;
  assign illegal_op = (cur_state == DECODE) && !op_known;

  // Next-state decode; unused encodings fall back to FETCH.
  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH:  nxt_state = DECODE;
      DECODE: begin
        if (op == OP_R)                        nxt_state = REXE;
        else if ((op == OP_LW) || (op == OP_SW)) nxt_state = MEMADR;
        else if (op == OP_BEQ)                 nxt_state = BRANCH;
        else if (op == OP_J)                   nxt_state = JUMP;
        else if (op == OP_ADDI)                nxt_state = IEXE;
        else                                   nxt_state = FETCH;
      end
      MEMADR: begin
        if (op == OP_LW) nxt_state = MEMRD;
        else             nxt_state = MEMWR;
      end
      MEMRD:  nxt_state = MEMWB;
      REXE:   nxt_state = RWB;
      IEXE:   nxt_state = IWB;
      default: nxt_state = FETCH;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      instr_cnt <= {CNT_W{1'b0}};
    end else begin
      if (hold) cur_state <= cur_state;
      else      cur_state <= nxt_state;
      if (retire) instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      else        instr_cnt <= instr_cnt;
    end
  end

  // Moore output decode; FETCH strobes wait for memory so the PC moves once.
  always_comb begin
    pc_write_cond = 1'b0;
    pc_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem2reg       = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_ctrl_op   = 2'b00;
    case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
        pc_source = 2'b01;
        alu_src_b = 2'b01;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR, IEXE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write = 1'b1;
        mem2reg   = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      REXE: begin
        alu_src_a   = 2'b01;
        alu_ctrl_op = 2'b10;
      end
      RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 2'b01;
        alu_ctrl_op   = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b00;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      IWB: reg_write = 1'b1;
      default: pc_source = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven, scoreboarded bench for mc_ctrl (CNT_W=4 so the wrap is reachable).
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write_cond, pc_write, iord, mem_read, mem_write, mem2reg;
  logic       ir_write, reg_dst, reg_write, illegal_op;
  logic [1:0] pc_source, alu_src_a, alu_src_b, alu_ctrl_op;
  logic [3:0] state;
  logic [3:0] instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt;

  typedef struct {
    logic [5:0]  op;
    int          len;
    logic [23:0] seq;     // state nibbles, first state in the top nibble
    logic        retires;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] outs;
    logic        ill;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  mc_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write_cond(pc_write_cond), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl_op(alu_ctrl_op), .illegal_op(illegal_op), .state(state),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  wire [16:0] act_outs = {pc_write_cond, pc_write, iord, mem_read, mem_write,
                          mem2reg, ir_write, reg_dst, reg_write,
                          pc_source, alu_src_a, alu_src_b, alu_ctrl_op};

  function automatic logic [16:0] exp_outs(input logic [3:0] s);
    logic pwc, pw, io, mr, mw, m2r, irw, rd, rw;
    logic [1:0] ps, sa, sbm, aop;
    {pwc, pw, io, mr, mw, m2r, irw, rd, rw} = 9'd0;
    ps = 2'b00; sa = 2'b00; sbm = 2'b00; aop = 2'b00;
    case (s)
      4'd0:  begin mr = 1'b1; irw = 1'b1; pw = 1'b1; ps = 2'b01; sbm = 2'b01; end
      4'd1:  sbm = 2'b11;
      4'd2, 4'd10: begin sa = 2'b01; sbm = 2'b10; end
      4'd3:  begin mr = 1'b1; io = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mw = 1'b1; io = 1'b1; end
      4'd6:  begin sa = 2'b01; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 2'b01; aop = 2'b01; pwc = 1'b1; ps = 2'b00; end
      4'd9:  begin pw = 1'b1; ps = 2'b10; end
      4'd11: rw = 1'b1;
      default: ;
    endcase
    return {pwc, pw, io, mr, mw, m2r, irw, rd, rw, ps, sa, sbm, aop};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Push the expectation for this cycle, then pop and compare it against the DUT.
  task automatic score_cycle(input logic [3:0] st, input logic ill);
    exp_t e;
    e.st = st; e.outs = exp_outs(st); e.ill = ill;
    sb.push_back(e);
    e = sb.pop_front();
    check("state", {28'd0, state}, {28'd0, e.st});
    check("outputs", {15'd0, act_outs}, {15'd0, e.outs});
    check("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] s;
    op = v.op;
    for (int k = 0; k < v.len; k++) begin
      s = v.seq[23 - 4*k -: 4];
      score_cycle(s, (s == 4'd1) && !v.retires);
      @(negedge clk);
    end
    if (v.retires) exp_cnt = exp_cnt + 4'd1;
    check("instr_cnt", {28'd0, instr_cnt}, {28'd0, exp_cnt});
  endtask

  initial begin
    vecs[0] = '{6'd0,  4, 24'h016700, 1'b1};
    vecs[1] = '{6'd35, 5, 24'h012340, 1'b1};
    vecs[2] = '{6'd43, 4, 24'h012500, 1'b1};
    vecs[3] = '{6'd4,  3, 24'h018000, 1'b1};
    vecs[4] = '{6'd2,  3, 24'h019000, 1'b1};
    vecs[5] = '{6'd8,  4, 24'h01AB00, 1'b1};
    vecs[6] = '{6'd63, 2, 24'h010000, 1'b0};
    vecs[7] = '{6'd1,  2, 24'h010000, 1'b0};

    rst_n = 1'b0; op = 6'd0; mem_ready = 1'b1; exp_cnt = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_cnt", {28'd0, instr_cnt}, 32'd0);
    check("reset_outs", {15'd0, act_outs}, {15'd0, exp_outs(4'd0)});
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Asynchronous reset landing in MEMRD between edges.
    op = 6'd35;
    repeat (3) @(negedge clk);
    check("pre_reset_memrd", {28'd0, state}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", {28'd0, state}, 32'd0);
    check("async_rst_cnt", {28'd0, instr_cnt}, 32'd0);
    exp_cnt = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_fetch", {28'd0, state}, 32'd0);

    // Sixteen R-type instructions wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) run_vec(vecs[0]);
    check("cnt_wrap", {28'd0, instr_cnt}, 32'd0);

`ifdef MC_CTRL_MEM_WAIT_EN
    op = 6'd0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_state", {28'd0, state}, 32'd0);
      check("stall_pc_write", {31'd0, pc_write}, 32'd0);
      check("stall_ir_write", {31'd0, ir_write}, 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check("ready_pc_write", {31'd0, pc_write}, 32'd1);
    @(negedge clk);
    check("after_stall_decode", {28'd0, state}, 32'd1);
    check("after_stall_pc_write", {31'd0, pc_write}, 32'd0);
    repeat (3) @(negedge clk);
    exp_cnt = exp_cnt + 4'd1;
    check("stall_instr_cnt", {28'd0, instr_cnt}, {28'd0, exp_cnt});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
